// File: rtl/axi_inval_pkg.sv
// Shared types and helpers for the burst-aware multi-hart invalidation splitter.
// FIFO entries are sized for the widest supported configuration.
package axi_inval_pkg;

  localparam int unsigned MaxAddrW = 64;
  localparam int unsigned MaxNlW   = 32;
  localparam int unsigned MaxHarts = 8;

  typedef struct packed {
    logic [MaxAddrW-1:0] line;
    logic [MaxNlW-1:0]   nlines;
    logic [MaxHarts-1:0] mask;
  } inval_entry_t;

  function automatic int unsigned log2_line(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  // Every burst is treated as INCR; FIXED bursts over-invalidate, which is safe.
  function automatic logic [MaxAddrW-1:0] line_count(
    input logic [MaxAddrW-1:0] addr,
    input logic [MaxAddrW-1:0] len,
    input logic [2:0]          size,
    input int unsigned         lg
  );
    logic [MaxAddrW-1:0] bytes;
    logic [MaxAddrW-1:0] last;
    bytes = (len + 64'd1) << size;
    last  = addr + bytes - 64'd1;
    return (last >> lg) - (addr >> lg) + 64'd1;
  endfunction

endpackage

// File: rtl/inval_line_fifo.sv
// Synchronous FIFO of pending invalidation entries.
// A pop frees its slot in the same cycle, so push is accepted when full and popping.
module inval_line_fifo
  import axi_inval_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  inval_entry_t data_i,
  input  logic         pop_i,
  output inval_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  inval_entry_t    r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == CntW'(Depth));
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_inval_splitter_mc.sv
// Splits vector AW bursts into per-line invalidations broadcast to enabled harts,
// and holds each write's B response until all of its invalidations are acknowledged.
module axi_inval_splitter_mc
  import axi_inval_pkg::*;
#(
  parameter int unsigned NrHarts     = 2,
  parameter int unsigned MaxTxns     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineBytes = 16,
  parameter int unsigned AxiLenWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NrHarts-1:0]     en_i,
  input  logic                   slv_aw_valid_i,
  output logic                   slv_aw_ready_o,
  input  logic [AddrWidth-1:0]   slv_aw_addr_i,
  input  logic [AxiLenWidth-1:0] slv_aw_len_i,
  input  logic [2:0]             slv_aw_size_i,
  output logic                   mst_aw_valid_o,
  input  logic                   mst_aw_ready_i,
  input  logic                   mst_b_valid_i,
  output logic                   mst_b_ready_o,
  output logic                   slv_b_valid_o,
  input  logic                   slv_b_ready_i,
  output logic [AddrWidth-1:0]   inval_addr_o,
  output logic [NrHarts-1:0]     inval_valid_o,
  input  logic [NrHarts-1:0]     inval_ready_i
);

  localparam int unsigned Log   = log2_line(L1LineBytes);
  localparam int unsigned NlW   = AxiLenWidth + 8;
  localparam int unsigned CredW = $clog2(MaxTxns + 1);

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_e;

  state_e             r_state, w_state_nx;
  logic [AddrWidth-1:0] r_line, w_line_nx;
  logic [NlW-1:0]     r_left, w_left_nx;
  logic [NrHarts-1:0] r_pending, w_pend_nx;
  logic [CredW-1:0]   r_credit;

  inval_entry_t       w_push_entry;
  inval_entry_t       w_head;
  logic [NlW-1:0]     w_nl;
  logic [NlW-1:0]     w_head_nl;
  logic [NrHarts-1:0] w_head_mask;
  logic [NrHarts-1:0] w_rem;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_aw_room;
  logic               w_credit_ok;
  logic               w_credit_room;
  logic               w_b_fire;

  // AW pass-through; a pop this cycle frees a slot for the incoming write.
  assign w_aw_room      = ~w_full | w_pop;
  assign mst_aw_valid_o = slv_aw_valid_i & w_aw_room;
  assign slv_aw_ready_o = mst_aw_ready_i & w_aw_room;
  assign w_push         = slv_aw_valid_i & slv_aw_ready_o;

  assign w_nl = NlW'(line_count(MaxAddrW'(slv_aw_addr_i), MaxAddrW'(slv_aw_len_i),
                                slv_aw_size_i, Log));

  always_comb begin
    w_push_entry        = '0;
    w_push_entry.line   = MaxAddrW'(slv_aw_addr_i) >> Log;
    w_push_entry.nlines = (|en_i) ? MaxNlW'(w_nl) : '0;
    w_push_entry.mask   = MaxHarts'(en_i);
  end

  inval_line_fifo #(
    .Depth (MaxTxns)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_head_nl   = NlW'(w_head.nlines);
  assign w_head_mask = NrHarts'(w_head.mask);

  assign w_credit_ok   = (r_credit != '0);
  assign slv_b_valid_o = mst_b_valid_i & w_credit_ok;
  assign mst_b_ready_o = slv_b_ready_i & w_credit_ok;
  assign w_b_fire      = mst_b_valid_i & slv_b_ready_i & w_credit_ok;
  // A completion waits only if the credit counter is saturated and no B drains it.
  assign w_credit_room = (r_credit != CredW'(MaxTxns)) | w_b_fire;

  assign inval_valid_o = r_pending;
  assign inval_addr_o  = (r_state == S_ISSUE) ? (r_line << Log) : '0;
  assign w_rem         = r_pending & ~inval_ready_i;

  always_comb begin
    w_state_nx = r_state;
    w_line_nx  = r_line;
    w_left_nx  = r_left;
    w_pend_nx  = r_pending;
    w_pop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if ((w_head_nl == '0) || (w_head_mask == '0)) begin
            w_pop = w_credit_room;
          end else begin
            w_line_nx  = AddrWidth'(w_head.line);
            w_left_nx  = w_head_nl;
            w_pend_nx  = w_head_mask;
            w_state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_pend_nx = w_rem;
        if (w_rem == '0) begin
          if (r_left == NlW'(1)) begin
            if (w_credit_room) begin
              w_pop      = 1'b1;
              w_state_nx = S_IDLE;
            end
          end else begin
            w_line_nx = r_line + 1'b1;
            w_left_nx = r_left - 1'b1;
            w_pend_nx = w_head_mask;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_line    <= '0;
      r_left    <= '0;
      r_pending <= '0;
      r_credit  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_line    <= w_line_nx;
      r_left    <= w_left_nx;
      r_pending <= w_pend_nx;
      case ({w_pop, w_b_fire})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_inval_splitter_mc.sv
// Directed bench for axi_inval_splitter_mc: line splitting, per-hart broadcast,
// B gating, FIFO back-pressure and mid-operation reset.
module tb_axi_inval_splitter_mc;

  localparam int unsigned NrHarts = 2;
  localparam int unsigned AddrW   = 64;
  localparam int unsigned LenW    = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NrHarts-1:0] en;
  logic               aw_valid;
  logic               aw_ready;
  logic [AddrW-1:0]   aw_addr;
  logic [LenW-1:0]    aw_len;
  logic [2:0]         aw_size;
  logic               m_aw_valid;
  logic               m_aw_ready;
  logic               m_b_valid;
  logic               m_b_ready;
  logic               s_b_valid;
  logic               s_b_ready;
  logic [AddrW-1:0]   inv_addr;
  logic [NrHarts-1:0] inv_valid;
  logic [NrHarts-1:0] inv_ready;

  int errors = 0;
  int checks = 0;
  int k;
  int nb;

  axi_inval_splitter_mc #(
    .NrHarts     (NrHarts),
    .MaxTxns     (4),
    .AddrWidth   (AddrW),
    .L1LineBytes (16),
    .AxiLenWidth (LenW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .slv_aw_valid_i (aw_valid),
    .slv_aw_ready_o (aw_ready),
    .slv_aw_addr_i  (aw_addr),
    .slv_aw_len_i   (aw_len),
    .slv_aw_size_i  (aw_size),
    .mst_aw_valid_o (m_aw_valid),
    .mst_aw_ready_i (m_aw_ready),
    .mst_b_valid_i  (m_b_valid),
    .mst_b_ready_o  (m_b_ready),
    .slv_b_valid_o  (s_b_valid),
    .slv_b_ready_i  (s_b_ready),
    .inval_addr_o   (inv_addr),
    .inval_valid_o  (inv_valid),
    .inval_ready_i  (inv_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    aw_valid = 1'b1;
    aw_addr  = a;
    aw_len   = l;
    aw_size  = s;
  endtask

  initial begin
    rst = 1'b1; en = '0; aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0;
    m_aw_ready = 1'b0; m_b_valid = 1'b1; s_b_ready = 1'b1; inv_ready = '0;
    tick(); tick();
    chk("rst_inval_valid", 64'(inv_valid), 64'd0);
    chk("rst_inval_addr", inv_addr, 64'd0);
    chk("rst_slv_b_valid", 64'(s_b_valid), 64'd0);
    chk("rst_mst_b_ready", 64'(m_b_ready), 64'd0);
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    rst = 1'b0; m_b_valid = 1'b0; m_aw_ready = 1'b1;

    // 0x1008 + 32 bytes spans three 16-byte lines.
    en = 2'b11; aw(64'h1008, 8'd3, 3'd3); #1;
    chk("t1_aw_ready", 64'(aw_ready), 64'd1);
    chk("t1_mst_aw_valid", 64'(m_aw_valid), 64'd1);
    tick(); aw_valid = 1'b0; m_b_valid = 1'b1; #1;
    chk("t1_valid_lat", 64'(inv_valid), 64'd0);
    chk("t1_b_held0", 64'(s_b_valid), 64'd0);
    tick();
    chk("t1_valid_l0", 64'(inv_valid), 64'd3);
    chk("t1_addr_l0", inv_addr, 64'h1000);
    inv_ready = 2'b11; tick();
    chk("t1_addr_l1", inv_addr, 64'h1010);
    chk("t1_valid_l1", 64'(inv_valid), 64'd3);
    chk("t1_b_held1", 64'(s_b_valid), 64'd0);
    tick();
    chk("t1_addr_l2", inv_addr, 64'h1020);
    chk("t1_b_held2", 64'(s_b_valid), 64'd0);
    tick();
    chk("t1_valid_done", 64'(inv_valid), 64'd0);
    chk("t1_b_pass", 64'(s_b_valid), 64'd1);
    chk("t1_mst_b_ready", 64'(m_b_ready), 64'd1);
    tick();
    chk("t1_b_consumed", 64'(s_b_valid), 64'd0);
    m_b_valid = 1'b0; inv_ready = '0;

    // Single line to hart 0 only; later en_i change must not matter.
    en = 2'b01; aw(64'h2000, 8'd0, 3'd3);
    tick(); aw_valid = 1'b0; en = 2'b11;
    tick();
    chk("t2_valid", 64'(inv_valid), 64'd1);
    chk("t2_addr", inv_addr, 64'h2000);
    m_b_valid = 1'b1; #1;
    chk("t2_b_held", 64'(s_b_valid), 64'd0);
    inv_ready = 2'b01; tick();
    chk("t2_valid_done", 64'(inv_valid), 64'd0);
    chk("t2_b_pass", 64'(s_b_valid), 64'd1);
    tick();
    chk("t2_b_consumed", 64'(s_b_valid), 64'd0);
    m_b_valid = 1'b0; inv_ready = '0;

    // No harts enabled: zero-line entry, B released once it pops.
    en = 2'b00; aw(64'h2800, 8'd1, 3'd3);
    tick(); aw_valid = 1'b0; m_b_valid = 1'b1; #1;
    chk("t3_valid0", 64'(inv_valid), 64'd0);
    chk("t3_b_held", 64'(s_b_valid), 64'd0);
    tick();
    chk("t3_valid1", 64'(inv_valid), 64'd0);
    chk("t3_b_pass", 64'(s_b_valid), 64'd1);
    tick();
    chk("t3_b_consumed", 64'(s_b_valid), 64'd0);
    m_b_valid = 1'b0;

    // Hart 1 stalls: hart 0 drops after its ack, line holds until hart 1 acks.
    en = 2'b11; aw(64'h3000, 8'd1, 3'd4);
    tick(); aw_valid = 1'b0;
    tick();
    chk("t4_valid_both", 64'(inv_valid), 64'd3);
    chk("t4_addr0", inv_addr, 64'h3000);
    inv_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_valid_h1", 64'(inv_valid), 64'd2);
      chk("t4_addr_hold", inv_addr, 64'h3000);
    end
    inv_ready = 2'b10; tick();
    chk("t4_valid_l1", 64'(inv_valid), 64'd3);
    chk("t4_addr_l1", inv_addr, 64'h3010);
    inv_ready = 2'b11; tick();
    chk("t4_valid_done", 64'(inv_valid), 64'd0);
    m_b_valid = 1'b1; #1;
    chk("t4_b_pass", 64'(s_b_valid), 64'd1);
    tick(); m_b_valid = 1'b0; inv_ready = '0;

    // Fill the FIFO, then release: 5th AW enters on the first pop.
    en = 2'b11;
    for (int i = 0; i < 4; i++) begin
      aw(64'h4000 + 64'(i) * 64'h100, 8'd0, 3'd0); #1;
      chk("t5_aw_ready_fill", 64'(aw_ready), 64'd1);
      tick();
    end
    aw(64'h4400, 8'd0, 3'd0); #1;
    chk("t5_full_aw_ready", 64'(aw_ready), 64'd0);
    chk("t5_full_mst_valid", 64'(m_aw_valid), 64'd0);
    tick();
    chk("t5_still_full", 64'(aw_ready), 64'd0);
    inv_ready = 2'b11; #1;
    chk("t5_pop_aw_ready", 64'(aw_ready), 64'd1);
    chk("t5_pop_mst_valid", 64'(m_aw_valid), 64'd1);
    chk("t5_head_addr", inv_addr, 64'h4000);
    tick(); aw_valid = 1'b0; m_b_valid = 1'b1; s_b_ready = 1'b1; #1;
    k = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (inv_valid != '0) begin
        chk("t5_drain_addr", inv_addr, 64'h4100 + 64'(k) * 64'h100);
        k++;
      end
      if (s_b_valid && s_b_ready) nb++;
      tick();
    end
    chk("t5_lines_seen", 64'(k), 64'd4);
    chk("t5_b_count", 64'(nb), 64'd5);
    chk("t5_idle", 64'(inv_valid), 64'd0);

    // Reset with a credit and two entries pending.
    m_b_valid = 1'b0; inv_ready = '0;
    en = 2'b00; aw(64'h5000, 8'd0, 3'd0); tick();
    en = 2'b11; aw(64'h5100, 8'd0, 3'd0); tick();
    aw(64'h5200, 8'd0, 3'd0); tick();
    aw_valid = 1'b0; #1;
    chk("t6_pre_valid", 64'(inv_valid), 64'd3);
    chk("t6_pre_addr", inv_addr, 64'h5100);
    m_b_valid = 1'b1; #1;
    chk("t6_pre_credit", 64'(s_b_valid), 64'd1);
    rst = 1'b1; tick();
    chk("t6_rst_valid", 64'(inv_valid), 64'd0);
    chk("t6_rst_addr", inv_addr, 64'd0);
    chk("t6_rst_b_valid", 64'(s_b_valid), 64'd0);
    chk("t6_rst_b_ready", 64'(m_b_ready), 64'd0);
    rst = 1'b0; m_b_valid = 1'b0; inv_ready = 2'b11;
    aw(64'h6000, 8'd0, 3'd0); #1;
    chk("t6_cold_aw_ready", 64'(aw_ready), 64'd1);
    tick(); aw_valid = 1'b0;
    tick();
    chk("t6_cold_valid", 64'(inv_valid), 64'd3);
    chk("t6_cold_addr", inv_addr, 64'h6000);
    tick();
    chk("t6_cold_done", 64'(inv_valid), 64'd0);
    m_b_valid = 1'b1; #1;
    chk("t6_cold_b", 64'(s_b_valid), 64'd1);
    tick(); tick();
    chk("t6_no_stale", 64'(inv_valid), 64'd0);
    chk("t6_b_drained", 64'(s_b_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
